musk_bus_arbiter: RTL and testbench

- Shares the single Muskbus memory port between the instruction-fetch cache (I side) and the data cache (D side).
- Allows one outstanding transaction at a time.
- Sequences each transaction through issue and response phases and routes response strobes back to the owning requester.
- Applies fixed D-side priority with an I-side anti-starvation override. Data beats bypass the arbiter; only control and address are arbitrated.

---
 rtl/musk_bus_arbiter_pkg.sv | 9 +
 rtl/musk_bus_arbiter_if.sv | 23 ++
 rtl/musk_bus_arbiter_starve_ctr.sv | 27 ++
 rtl/musk_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_musk_bus_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/musk_bus_arbiter_pkg.sv
// Shared types and constants for the Muskbus I/D arbiter.
package MuskArbPkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} arb_state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} arb_owner_t;

   localparam int ARB_CNT_W = 8;

endpackage

// File: rtl/musk_bus_arbiter_if.sv
// Muskbus memory-port signals; the arbiter is the master, the memory side the slave.
interface musk_bus_arbiter_if #(
   parameter int ADDR_W = 64
);

   logic              m_req;
   logic [ADDR_W-1:0] m_addr;
   logic              m_write;
   logic              m_ready;
   logic              m_resp_valid;
   logic              m_resp_last;

   modport master (
      output m_req, m_addr, m_write,
      input  m_ready, m_resp_valid, m_resp_last
   );

   modport slave (
      input  m_req, m_addr, m_write,
      output m_ready, m_resp_valid, m_resp_last
   );

endinterface

// File: rtl/musk_bus_arbiter_starve_ctr.sv
// Saturating count of D grants taken while I was waiting; at_limit forces I to win.
module arb_starve_ctr
   import MuskArbPkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 inc,
   input  logic                 clr,
   input  logic [ARB_CNT_W-1:0] limit,
   output logic                 at_limit
);

   logic [ARB_CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt < limit)) begin
         cnt <= cnt + ARB_CNT_W'(1);
      end
   end

   assign at_limit = (cnt == limit);

endmodule

// File: rtl/musk_bus_arbiter.sv
// Single-outstanding arbiter sharing the Muskbus port between I and D caches.
// Optional response watchdog enabled by defining MUSK_ARB_TIMEOUT_EN.
module musk_bus_arbiter
   import MuskArbPkg::*;
#(
   parameter int ADDR_W         = 64,
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                clk,
   input  logic                reset,

   input  logic                i_req,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_gnt,
   output logic                i_resp_valid,
   output logic                i_resp_last,

   input  logic                d_req,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic                d_write,
   output logic                d_gnt,
   output logic                d_resp_valid,
   output logic                d_resp_last,

   musk_bus_arbiter_if.master  bus,

   output logic                busy,
   output logic                arb_timeout
);

   localparam logic [ARB_CNT_W-1:0] STARVE_LIM = ARB_CNT_W'(STARVE_LIMIT);

   arb_state_t        state;
   arb_owner_t        owner;
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;

   logic starve_at_limit;
   logic any_req;
   logic d_wins;
   logic issuing;
   logic waiting;
   logic final_beat;
   logic tmo_fire;
   logic own_resp_valid;
   logic own_resp_last;

   assign any_req    = i_req || d_req;
   assign d_wins     = d_req && !(i_req && starve_at_limit);
   assign issuing    = (state == ISSUE);
   assign waiting    = (state == WAIT_RESP);
   assign final_beat = waiting && bus.m_resp_valid && bus.m_resp_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         owner <= OWN_NONE;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state <= ISSUE;
                  owner <= d_wins ? OWN_D : OWN_I;
               end
            end
            ISSUE: begin
               if (bus.m_ready) begin
                  state <= WAIT_RESP;
               end
            end
            WAIT_RESP: begin
               if (final_beat || tmo_fire) begin
                  state <= IDLE;
                  owner <= OWN_NONE;
               end
            end
            default: begin
               state <= IDLE;
               owner <= OWN_NONE;
            end
         endcase
      end
   end

   // Address/write latch is datapath only; outputs are gated by state instead of reset.
   always_ff @(posedge clk) begin
      if ((state == IDLE) && any_req) begin
         addr_q  <= d_wins ? d_addr : i_addr;
         write_q <= d_wins && d_write;
      end
   end

   assign bus.m_req   = issuing;
   assign bus.m_addr  = issuing ? addr_q : '0;
   assign bus.m_write = issuing && write_q;

   assign i_gnt = issuing && bus.m_ready && (owner == OWN_I);
   assign d_gnt = issuing && bus.m_ready && (owner == OWN_D);

   assign own_resp_valid = waiting && (bus.m_resp_valid || tmo_fire);
   assign own_resp_last  = waiting && (bus.m_resp_last  || tmo_fire);

   assign i_resp_valid = own_resp_valid && (owner == OWN_I);
   assign i_resp_last  = own_resp_last  && (owner == OWN_I);
   assign d_resp_valid = own_resp_valid && (owner == OWN_D);
   assign d_resp_last  = own_resp_last  && (owner == OWN_D);

   assign busy = (state != IDLE);

   arb_starve_ctr u_starve (
      .clk      (clk),
      .reset    (reset),
      .inc      (d_gnt && i_req),
      .clr      (i_gnt),
      .limit    (STARVE_LIM),
      .at_limit (starve_at_limit)
   );

`ifdef MUSK_ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_err;

   // Held at zero through ISSUE so the count starts fresh on the first wait cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt <= '0;
         tmo_err <= 1'b0;
      end else begin
         if (issuing) begin
            tmo_cnt <= '0;
         end else if (waiting && !final_beat) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         end
         if (tmo_fire) begin
            tmo_err <= 1'b1;
         end
      end
   end

   assign tmo_fire    = waiting && !final_beat && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
   assign arb_timeout = tmo_err;
`else
   assign tmo_fire    = 1'b0;
   assign arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_musk_bus_arbiter.sv
// Directed bench for musk_bus_arbiter with grant/response scoreboards.
module tb_musk_bus_arbiter;

   localparam int ADDR_W = 64;
   localparam int SLIM   = 4;
   localparam int TMO    = 16;

   typedef struct packed {
      logic is_d;
      logic last;
   } resp_t;

   logic              clk;
   logic              reset;
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt;
   logic              i_resp_valid;
   logic              i_resp_last;
   logic              d_req;
   logic [ADDR_W-1:0] d_addr;
   logic              d_write;
   logic              d_gnt;
   logic              d_resp_valid;
   logic              d_resp_last;
   logic              busy;
   logic              arb_timeout;

   int n_assert = 0;
   int n_fail   = 0;
   int n_i_beats = 0;
   int n_i_lasts = 0;

   logic  gnt_q[$];
   resp_t resp_q[$];
   logic  mon_eg;
   resp_t mon_er;

   musk_bus_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   musk_bus_arbiter #(
      .ADDR_W         (ADDR_W),
      .STARVE_LIMIT   (SLIM),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i_req        (i_req),
      .i_addr       (i_addr),
      .i_gnt        (i_gnt),
      .i_resp_valid (i_resp_valid),
      .i_resp_last  (i_resp_last),
      .d_req        (d_req),
      .d_addr       (d_addr),
      .d_write      (d_write),
      .d_gnt        (d_gnt),
      .d_resp_valid (d_resp_valid),
      .d_resp_last  (d_resp_last),
      .bus          (bus),
      .busy         (busy),
      .arb_timeout  (arb_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mreq"},  64'(bus.m_req), 64'd0);
      chk({tag, "_maddr"}, bus.m_addr, 64'd0);
      chk({tag, "_mwr"},   64'(bus.m_write), 64'd0);
      chk({tag, "_gnt"},   64'({d_gnt, i_gnt}), 64'd0);
      chk({tag, "_resp"},  64'({d_resp_valid, d_resp_last, i_resp_valid, i_resp_last}), 64'd0);
      chk({tag, "_busy"},  64'(busy), 64'd0);
      chk({tag, "_tmo"},   64'(arb_timeout), 64'd0);
   endtask

   // Grant and response scoreboards: expectations pushed by stimulus, popped here.
   always @(negedge clk) begin
      if (!reset) begin
         if (i_gnt || d_gnt) begin
            if (gnt_q.size() == 0) begin
               chk("gnt_spurious", 64'({d_gnt, i_gnt}), 64'd0);
            end else begin
               mon_eg = gnt_q.pop_front();
               chk("gnt_owner", 64'({d_gnt, i_gnt}), mon_eg ? 64'd2 : 64'd1);
            end
         end
         if (i_resp_valid || d_resp_valid) begin
            if (i_resp_valid) n_i_beats++;
            if (i_resp_valid && i_resp_last) n_i_lasts++;
            if (resp_q.size() == 0) begin
               chk("resp_spurious", 64'({d_resp_valid, i_resp_valid}), 64'd0);
            end else begin
               mon_er = resp_q.pop_front();
               chk("resp_owner", 64'({d_resp_valid, i_resp_valid}), mon_er.is_d ? 64'd2 : 64'd1);
               chk("resp_last", 64'({d_resp_last, i_resp_last}),
                   mon_er.is_d ? 64'({mon_er.last, 1'b0}) : 64'({1'b0, mon_er.last}));
            end
         end
      end
   end

   // Called in an IDLE cycle with requests already driven; runs one full transaction.
   task automatic run_txn(input logic exp_d, input logic [63:0] exp_addr, input logic exp_wr,
                          input int ready_delay, input int beats);
      gnt_q.push_back(exp_d);
      cyc();
      for (int k = 0; k < ready_delay; k++) begin
         #2;
         chk("stall_m_req",   64'(bus.m_req), 64'd1);
         chk("stall_m_addr",  bus.m_addr, exp_addr);
         chk("stall_m_write", 64'(bus.m_write), 64'(exp_wr));
         chk("stall_gnt",     64'({d_gnt, i_gnt}), 64'd0);
         cyc();
      end
      bus.m_ready = 1'b1;
      #2;
      chk("issue_m_req",   64'(bus.m_req), 64'd1);
      chk("issue_m_addr",  bus.m_addr, exp_addr);
      chk("issue_m_write", 64'(bus.m_write), 64'(exp_wr));
      chk("issue_gnt",     64'({d_gnt, i_gnt}), exp_d ? 64'd2 : 64'd1);
      cyc();
      bus.m_ready = 1'b0;
      if (exp_d) d_req = 1'b0;
      else       i_req = 1'b0;
      for (int k = 0; k < beats; k++) begin
         bus.m_resp_valid = 1'b1;
         bus.m_resp_last  = (k == beats - 1);
         resp_q.push_back('{is_d: exp_d, last: (k == beats - 1)});
         #2;
         chk("wait_busy", 64'(busy), 64'd1);
         chk("wait_m_req", 64'(bus.m_req), 64'd0);
         cyc();
      end
      bus.m_resp_valid = 1'b0;
      bus.m_resp_last  = 1'b0;
      #2;
      chk("done_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int   sc;
      logic ed;
      logic ia;

      reset = 1'b1;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_addr = '0; d_write = 1'b0;
      bus.m_ready = 1'b0; bus.m_resp_valid = 1'b0; bus.m_resp_last = 1'b0;
      #2;
      chk_all_zero("reset");
      cyc();
      cyc();
      reset = 1'b0;
      cyc();

      // Single I read, eight beats.
      i_req = 1'b1; i_addr = 64'h1000;
      #2;
      chk("t1_pre_m_req", 64'(bus.m_req), 64'd0);
      run_txn(1'b0, 64'h1000, 1'b0, 0, 8);
      chk("t1_i_beats", 64'(n_i_beats), 64'd8);
      chk("t1_i_lasts", 64'(n_i_lasts), 64'd1);

      // Simultaneous requests: D wins until I has waited STARVE_LIMIT grants.
      sc = 0;
      for (int t = 0; t < 7; t++) begin
         if (t == 0 || t == 5) begin
            i_req  = 1'b1;
            i_addr = 64'hA000 + 64'(t * 64);
         end
         d_req   = (t < 6);
         d_addr  = 64'h3000 + 64'(t * 8);
         d_write = 1'b0;
         ed = d_req && !(i_req && (sc == SLIM));
         ia = i_req;
         run_txn(ed, ed ? d_addr : i_addr, 1'b0, 0, 1);
         if (ed) begin
            if (ia && sc < SLIM) sc++;
         end else begin
            sc = 0;
         end
      end

      // D write stalled by the bus for ten cycles.
      d_req = 1'b1; d_addr = 64'h2008; d_write = 1'b1;
      run_txn(1'b1, 64'h2008, 1'b1, 10, 1);
      d_write = 1'b0;

      // Reset in the middle of WAIT_RESP, then a stray response.
      i_req = 1'b1; i_addr = 64'h4000;
      gnt_q.push_back(1'b0);
      cyc();
      bus.m_ready = 1'b1;
      cyc();
      bus.m_ready = 1'b0; i_req = 1'b0;
      bus.m_resp_valid = 1'b1; bus.m_resp_last = 1'b0;
      resp_q.push_back('{is_d: 1'b0, last: 1'b0});
      cyc();
      #2;
      reset = 1'b1;
      #1;
      chk_all_zero("rst_mid");
      bus.m_resp_last = 1'b1;
      cyc();
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #2;
         chk_all_zero("rst_after");
         cyc();
      end
      bus.m_resp_valid = 1'b0; bus.m_resp_last = 1'b0;

      // Final beat coinciding with a new D request.
      d_req = 1'b1; d_addr = 64'h5000;
      gnt_q.push_back(1'b1);
      cyc();
      bus.m_ready = 1'b1;
      cyc();
      bus.m_ready = 1'b0; d_req = 1'b0;
      bus.m_resp_valid = 1'b1; bus.m_resp_last = 1'b1;
      resp_q.push_back('{is_d: 1'b1, last: 1'b1});
      d_req = 1'b1; d_addr = 64'h5040;
      cyc();
      bus.m_resp_valid = 1'b0; bus.m_resp_last = 1'b0;
      #2;
      chk("bubble_busy",  64'(busy), 64'd0);
      chk("bubble_m_req", 64'(bus.m_req), 64'd0);
      run_txn(1'b1, 64'h5040, 1'b0, 0, 1);

      // Silent bus after grant.
      i_req = 1'b1; i_addr = 64'h6000;
      gnt_q.push_back(1'b0);
      cyc();
      bus.m_ready = 1'b1;
      cyc();
      bus.m_ready = 1'b0; i_req = 1'b0;
`ifdef MUSK_ARB_TIMEOUT_EN
      for (int w = 1; w < TMO; w++) begin
         #2;
         chk("tmo_wait_resp", 64'(i_resp_valid), 64'd0);
         chk("tmo_wait_busy", 64'(busy), 64'd1);
         cyc();
      end
      resp_q.push_back('{is_d: 1'b0, last: 1'b1});
      #2;
      chk("tmo_force", 64'({i_resp_valid, i_resp_last}), 64'd3);
      chk("tmo_flag_pre", 64'(arb_timeout), 64'd0);
      cyc();
      #2;
      chk("tmo_flag", 64'(arb_timeout), 64'd1);
      chk("tmo_idle", 64'(busy), 64'd0);
      d_req = 1'b1; d_addr = 64'h7000;
      run_txn(1'b1, 64'h7000, 1'b0, 0, 1);
      chk("tmo_sticky", 64'(arb_timeout), 64'd1);
`else
      for (int w = 1; w <= TMO + 4; w++) begin
         #2;
         chk("notmo_resp", 64'({i_resp_valid, d_resp_valid}), 64'd0);
         chk("notmo_busy", 64'(busy), 64'd1);
         chk("notmo_flag", 64'(arb_timeout), 64'd0);
         cyc();
      end
      bus.m_resp_valid = 1'b1; bus.m_resp_last = 1'b1;
      resp_q.push_back('{is_d: 1'b0, last: 1'b1});
      cyc();
      bus.m_resp_valid = 1'b0; bus.m_resp_last = 1'b0;
      #2;
      chk("notmo_done", 64'(busy), 64'd0);
`endif

      cyc();
      chk("gnt_q_drained",  64'(gnt_q.size()), 64'd0);
      chk("resp_q_drained", 64'(resp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
